// File: rtl/seq_sorter_n.sv
// seq_sorter_n: streaming top-N sorter.
// Samples stream in over a valid/ready input. Each accepted sample is inserted
// into a sorted register array in a single cycle, using parallel compares and a
// shift. After the sample flagged in_last, the retained values drain in sorted
// order over a valid/ready output. Cell 0 always holds the best value.
module seq_sorter_n #(
    parameter int DW         = 8,
    parameter int DEPTH      = 4,
    parameter int DESCENDING = 1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // Control state
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Sort cells. A cell's valid bit separates a stored zero from an empty slot.
    logic [DW-1:0]    cell_q [DEPTH];
    logic [DW-1:0]    cell_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    // Per-cell candidates for an insertion step and for a drain (pop) step
    logic [DEPTH-1:0] beat;
    logic [DW-1:0]    ins_val [DEPTH];
    logic [DEPTH-1:0] ins_vld;
    logic [DW-1:0]    pop_val [DEPTH];
    logic [DEPTH-1:0] pop_vld;

    logic accept;
    logic pop;
    logic out_valid_w;
    logic out_last_w;

    genvar gi;

    // The new sample beats a cell when that cell is empty, or when the sample
    // is strictly better than the stored value. Because strict comparison is
    // used, a sample equal to a stored value lands after that value.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            if (DESCENDING != 0) begin : g_desc
                assign beat[gi] = !vld_q[gi] || (in_data > cell_q[gi]);
            end else begin : g_asc
                assign beat[gi] = !vld_q[gi] || (in_data < cell_q[gi]);
            end
        end
    endgenerate

    // The array is kept sorted, and valid cells are contiguous from cell 0, so
    // beat[] is monotonic: 0...0 then 1...1. The first set bit is the insertion
    // point. Every cell after it takes the value of its upper neighbour. The
    // value pushed out of the last cell is lost. A sample that beats nothing
    // leaves the array untouched.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ins
            if (gi == 0) begin : g_head
                assign ins_val[gi] = beat[gi] ? in_data : cell_q[gi];
                assign ins_vld[gi] = beat[gi] ? 1'b1    : vld_q[gi];
            end else begin : g_body
                assign ins_val[gi] = beat[gi-1] ? cell_q[gi-1] :
                                     beat[gi]   ? in_data      : cell_q[gi];
                assign ins_vld[gi] = beat[gi-1] ? vld_q[gi-1]  :
                                     beat[gi]   ? 1'b1         : vld_q[gi];
            end
        end
    endgenerate

    // A drain step moves every cell up by one. The bottom cell is left empty.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pop
            if (gi == DEPTH - 1) begin : g_tail
                assign pop_val[gi] = '0;
                assign pop_vld[gi] = 1'b0;
            end else begin : g_body
                assign pop_val[gi] = cell_q[gi+1];
                assign pop_vld[gi] = vld_q[gi+1];
            end
        end
    endgenerate

    // The result is the last one when there is nothing valid behind cell 0.
    generate
        if (DEPTH == 1) begin : g_last_one
            assign out_last_w = out_valid_w;
        end else begin : g_last_many
            assign out_last_w = out_valid_w && !vld_q[1];
        end
    endgenerate

    assign out_valid_w = (state_q == ST_DRAIN) && vld_q[0];
    assign accept      = (state_q == ST_LOAD) && in_valid;
    assign pop         = out_valid_w && out_ready;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = out_valid_w;
    assign out_last  = out_last_w;
    assign out_data  = (state_q == ST_DRAIN) ? cell_q[0] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Next-state logic for load (insert) and drain (pop), and the control state
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cell_d     = cell_q;
        vld_d      = vld_q;

        if (accept) begin
            cell_d = ins_val;
            vld_d  = ins_vld;
            // A full array means this sample, or the value it displaces, is dropped
            if (count_q == COUNT_FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (in_last) begin
                state_d = ST_DRAIN;
            end
        end

        if (pop) begin
            cell_d  = pop_val;
            vld_d   = pop_vld;
            count_d = count_q - 1'b1;
            if (out_last_w) begin
                state_d    = ST_LOAD;
                overflow_d = 1'b0;
                count_d    = '0;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // One value/valid register pair per sort cell
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cell_q[gi] <= '0;
                    vld_q[gi]  <= 1'b0;
                end else begin
                    cell_q[gi] <= cell_d[gi];
                    vld_q[gi]  <= vld_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_seq_sorter_n.sv
// Testbench for seq_sorter_n.
// It runs two instances on the same stimulus: one keeps the largest values
// (descending), the other keeps the smallest (ascending). Both are checked
// against hand-written vectors and against a sort-based reference model.
module tb_seq_sorter_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    logic       in_ready_d, out_valid_d, out_last_d, overflow_d;
    logic [7:0] out_data_d;
    logic [2:0] count_d;
    logic       in_ready_a, out_valid_a, out_last_a, overflow_a;
    logic [7:0] out_data_a;
    logic [2:0] count_a;

    always #5 clk = ~clk;

    seq_sorter_n #(.DW(8), .DEPTH(4), .DESCENDING(1)) dut_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_d),
        .out_valid(out_valid_d), .out_data(out_data_d), .out_last(out_last_d),
        .out_ready(out_ready), .count(count_d), .overflow(overflow_d)
    );

    seq_sorter_n #(.DW(8), .DEPTH(4), .DESCENDING(0)) dut_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a),
        .out_ready(out_ready), .count(count_a), .overflow(overflow_a)
    );

    int total = 0;
    int bad   = 0;

    int exp_d[$];
    int exp_a[$];
    int exp_ovf;
    int rdy_pat[$];

    typedef struct {
        int n;
        int v[8];
        int ne;
        int ed[4];
        int ea[4];
        int ovf;
        int mode;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: sort all samples, keep the four best in each direction
    function automatic void model(input int s[$]);
        int a[$];
        int tmp;
        int keep;
        a = s;
        for (int i = 0; i < a.size(); i++)
            for (int j = 0; j + 1 < a.size() - i; j++)
                if (a[j] < a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                end
        keep = (a.size() > 4) ? 4 : a.size();
        exp_d = {};
        exp_a = {};
        for (int i = 0; i < keep; i++) begin
            exp_d.push_back(a[i]);
            exp_a.push_back(a[a.size()-1-i]);
        end
        exp_ovf = (a.size() > 4) ? 1 : 0;
    endfunction

    // Present one sample for exactly one edge, then check the load-side status
    task automatic send(input int v, input bit last, input int k);
        int c;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v[7:0];
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        c = (k > 4) ? 4 : k;
        chk("load_count_desc", int'(count_d), c);
        chk("load_count_asc", int'(count_a), c);
        chk("load_ovf_desc", int'(overflow_d), (k > 4) ? 1 : 0);
        chk("load_ovf_asc", int'(overflow_a), (k > 4) ? 1 : 0);
        chk("load_in_ready", int'(in_ready_d), last ? 0 : 1);
        $display("load sample=%0d last=%0d count=%0d/%0d ovf=%0d/%0d",
                 v, last, count_d, count_a, overflow_d, overflow_a);
    endtask

    task automatic send_seq(input int s[$], input bit gaps);
        for (int k = 0; k < s.size(); k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            send(s[k], k == s.size() - 1, k + 1);
        end
    endtask

    // mode 0: always ready, 1: rdy_pat then ready, 2: random backpressure
    task automatic drain(input int mode);
        int n;
        int idx;
        int cyc;
        int pi;
        bit r;
        n = exp_d.size();
        idx = 0;
        cyc = 0;
        pi = 0;
        while (idx < n && cyc < 100) begin
            @(negedge clk);
            chk("drain_valid_desc", int'(out_valid_d), 1);
            chk("drain_valid_asc", int'(out_valid_a), 1);
            chk("drain_data_desc", int'(out_data_d), exp_d[idx]);
            chk("drain_data_asc", int'(out_data_a), exp_a[idx]);
            chk("drain_last_desc", int'(out_last_d), (idx == n - 1) ? 1 : 0);
            chk("drain_last_asc", int'(out_last_a), (idx == n - 1) ? 1 : 0);
            chk("drain_in_ready", int'(in_ready_d) + int'(in_ready_a), 0);
            chk("drain_count", int'(count_d), n - idx);
            chk("drain_ovf_desc", int'(overflow_d), exp_ovf);
            chk("drain_ovf_asc", int'(overflow_a), exp_ovf);
            if (mode == 0) r = 1'b1;
            else if (mode == 1) begin
                r = (pi < rdy_pat.size()) ? rdy_pat[pi][0] : 1'b1;
                pi++;
            end else r = 1'($urandom_range(0, 1));
            out_ready = r;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_last   = 1'($urandom_range(0, 1));
            $display("drain idx=%0d ready=%0d data=%0d/%0d last=%0d/%0d",
                     idx, r, out_data_d, out_data_a, out_last_d, out_last_a);
            @(posedge clk);
            if (r) idx++;
            cyc++;
        end
        chk("drain_complete", idx, n);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk("post_in_ready_desc", int'(in_ready_d), 1);
        chk("post_in_ready_asc", int'(in_ready_a), 1);
        chk("post_valid", int'(out_valid_d) + int'(out_valid_a), 0);
        chk("post_count", int'(count_d) + int'(count_a), 0);
        chk("post_ovf", int'(overflow_d) + int'(overflow_a), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[$];
        int len;

        tbl[0] = '{4, '{3, 7, 1, 5, 0, 0, 0, 0}, 4, '{7, 5, 3, 1}, '{1, 3, 5, 7}, 0, 0};
        tbl[1] = '{4, '{3, 7, 1, 5, 0, 0, 0, 0}, 4, '{7, 5, 3, 1}, '{1, 3, 5, 7}, 0, 1};
        tbl[2] = '{6, '{2, 9, 4, 9, 1, 8, 0, 0}, 4, '{9, 9, 8, 4}, '{1, 2, 4, 8}, 1, 0};
        tbl[3] = '{2, '{5, 2, 0, 0, 0, 0, 0, 0}, 2, '{5, 2, 0, 0}, '{2, 5, 0, 0}, 0, 0};
        tbl[4] = '{1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0};
        tbl[5] = '{5, '{3, 7, 1, 5, 0, 0, 0, 0}, 4, '{7, 5, 3, 1}, '{0, 1, 3, 5}, 1, 0};
        tbl[6] = '{5, '{255, 0, 255, 0, 128, 0, 0, 0}, 4, '{255, 255, 128, 0}, '{0, 0, 128, 255}, 1, 0};
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1};

        // Values while reset is held
        #12;
        chk("rst_valid", int'(out_valid_d) + int'(out_valid_a), 0);
        chk("rst_data", int'(out_data_d) + int'(out_data_a), 0);
        chk("rst_last", int'(out_last_d) + int'(out_last_a), 0);
        chk("rst_count", int'(count_d) + int'(count_a), 0);
        chk("rst_ovf", int'(overflow_d) + int'(overflow_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready_d) + int'(in_ready_a), 2);

        // Directed vectors
        for (int t = 0; t < 7; t++) begin
            s = {};
            for (int k = 0; k < tbl[t].n; k++) s.push_back(tbl[t].v[k]);
            exp_d = {};
            exp_a = {};
            for (int k = 0; k < tbl[t].ne; k++) begin
                exp_d.push_back(tbl[t].ed[k]);
                exp_a.push_back(tbl[t].ea[k]);
            end
            exp_ovf = tbl[t].ovf;
            $display("vector %0d: %0d samples", t, tbl[t].n);
            send_seq(s, 1'b0);
            drain(tbl[t].mode);
        end

        // Asynchronous reset in the middle of a drain, after the first output
        s = '{3, 7, 1, 5};
        send_seq(s, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        chk("mid_first_desc", int'(out_data_d), 7);
        chk("mid_first_asc", int'(out_data_a), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid_d) + int'(out_valid_a), 0);
        chk("mid_rst_count", int'(count_d) + int'(count_a), 0);
        chk("mid_rst_ovf", int'(overflow_d) + int'(overflow_a), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", int'(in_ready_d) + int'(in_ready_a), 2);
        chk("mid_rel_valid", int'(out_valid_d) + int'(out_valid_a), 0);
        $display("reset mid-drain: in_ready=%0d count=%0d", in_ready_d, count_d);
        s = '{4, 6};
        exp_d = '{6, 4};
        exp_a = '{4, 6};
        exp_ovf = 0;
        send_seq(s, 1'b0);
        drain(0);

        // Random sequences against the reference model
        for (int t = 0; t < 25; t++) begin
            s = {};
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++)
                s.push_back((t % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
            model(s);
            $display("random %0d: %0d samples", t, len);
            send_seq(s, 1'b1);
            drain(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
